// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multi-cycle RV32I core.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) for one instruction at a
// time over a shared instruction/data memory port, and parks in a sticky HALT
// on illegal opcodes, SYSTEM instructions or memory timeouts.
// Ports:
//   clk_i, rst_ni        clock (rising edge), async active-low reset
//   opcode_i             inst[6:0] from the instruction register
//   br_taken_i           branch compare result (EXEC)
//   mem_ready_i          memory completes the access this cycle
//   mem_req_o/mem_we_o   memory request / write strobe
//   mem_addr_sel_o       0 = PC, 1 = ALU result
//   ir_we_o              instruction-register load
//   ImmSel_o             registered immediate type (I/S/B/J/U codes)
//   alu_a_sel_o          0 = rs1, 1 = PC
//   alu_b_sel_o          0 = rs2, 1 = imm
//   pc_we_o, pc_sel_o    PC update, 0 = PC+4, 1 = PC+imm, 2 = ALU & ~1
//   rd_we_o, wb_sel_o    RF write, 0 = ALU, 1 = mem data, 2 = PC+4
//   halt_o, fault_o      sticky halt, 0 none / 1 illegal / 2 timeout / 3 SYSTEM

`ifndef I_TYPE
`define I_TYPE 3'd0
`endif
`ifndef S_TYPE
`define S_TYPE 3'd1
`endif
`ifndef B_TYPE
`define B_TYPE 3'd2
`endif
`ifndef U_TYPE
`define U_TYPE 3'd3
`endif
`ifndef J_TYPE
`define J_TYPE 3'd4
`endif

module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] opcode_i,
  input  logic       br_taken_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       mem_addr_sel_o,
  output logic       ir_we_o,
  output logic [2:0] ImmSel_o,
  output logic       alu_a_sel_o,
  output logic       alu_b_sel_o,
  output logic       pc_we_o,
  output logic [1:0] pc_sel_o,
  output logic       rd_we_o,
  output logic [1:0] wb_sel_o,
  output logic       halt_o,
  output logic [1:0] fault_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] FLT_NONE    = 2'd0;
  localparam logic [1:0] FLT_ILLEGAL = 2'd1;
  localparam logic [1:0] FLT_TIMEOUT = 2'd2;
  localparam logic [1:0] FLT_SYSTEM  = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH,
    C_LOAD, C_STORE, C_OPIMM, C_OP, C_FENCE
  } cls_t;

  state_t           r_state, w_state_nxt;
  cls_t             r_cls, w_cls_dec;
  logic [2:0]       r_imm_sel, w_imm_dec;
  logic [1:0]       w_dec_fault;
  logic [CNT_W-1:0] r_cnt;
  logic             r_halt;
  logic [1:0]       r_fault, w_fault_nxt;
  logic             w_mem_phase, w_timeout;

  logic       w_mem_req, w_mem_we, w_addr_sel, w_ir_we;
  logic       w_a_sel, w_b_sel, w_pc_we, w_rd_we;
  logic [1:0] w_pc_sel, w_wb_sel;

  assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);
  // Ready in the same cycle as the limit wins over the timeout.
  assign w_timeout   = (r_cnt == TIMEOUT) && !mem_ready_i;

  // Opcode classification; only consumed while in DECODE.
  always_comb begin
    w_cls_dec   = C_NONE;
    w_imm_dec   = `I_TYPE;
    w_dec_fault = FLT_NONE;
    case (opcode_i)
      OP_LUI:    begin w_cls_dec = C_LUI;    w_imm_dec = `U_TYPE; end
      OP_AUIPC:  begin w_cls_dec = C_AUIPC;  w_imm_dec = `U_TYPE; end
      OP_JAL:    begin w_cls_dec = C_JAL;    w_imm_dec = `J_TYPE; end
      OP_JALR:   w_cls_dec = C_JALR;
      OP_LOAD:   w_cls_dec = C_LOAD;
      OP_OPIMM:  w_cls_dec = C_OPIMM;
      OP_STORE:  begin w_cls_dec = C_STORE;  w_imm_dec = `S_TYPE; end
      OP_BRANCH: begin w_cls_dec = C_BRANCH; w_imm_dec = `B_TYPE; end
      OP_OP:     w_cls_dec = C_OP;
      OP_FENCE:  w_cls_dec = C_FENCE;
      OP_SYSTEM: w_dec_fault = FLT_SYSTEM;
      default:   w_dec_fault = FLT_ILLEGAL;
    endcase
  end

  // State, class, immediate select, wait counter and sticky fault registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_FETCH;
      r_cls     <= C_NONE;
      r_imm_sel <= 3'd0;
      r_cnt     <= '0;
      r_halt    <= 1'b0;
      r_fault   <= FLT_NONE;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_DECODE) begin
        r_cls     <= w_cls_dec;
        r_imm_sel <= w_imm_dec;
      end
      // Counter is held at zero outside FETCH/MEM, so entering either starts clean.
      if (w_mem_phase && !mem_ready_i) begin
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
      if ((w_state_nxt == S_HALT) && (r_state != S_HALT)) begin
        r_halt  <= 1'b1;
        r_fault <= w_fault_nxt;
      end
    end
  end

  // Next-state and per-state control outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_fault_nxt = FLT_NONE;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_addr_sel  = 1'b0;
    w_ir_we     = 1'b0;
    w_a_sel     = 1'b0;
    w_b_sel     = 1'b0;
    w_pc_we     = 1'b0;
    w_pc_sel    = 2'd0;
    w_rd_we     = 1'b0;
    w_wb_sel    = 2'd0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ready_i) begin
          w_ir_we     = 1'b1;
          w_state_nxt = S_DECODE;
        end else if (w_timeout) begin
          w_fault_nxt = FLT_TIMEOUT;
          w_state_nxt = S_HALT;
        end
      end
      S_DECODE: begin
        if (w_dec_fault != FLT_NONE) begin
          w_fault_nxt = w_dec_fault;
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_a_sel = (r_cls == C_AUIPC) || (r_cls == C_JAL) || (r_cls == C_BRANCH);
        w_b_sel = (r_cls != C_OP);
        case (r_cls)
          C_BRANCH: begin
            w_pc_we     = 1'b1;
            w_pc_sel    = br_taken_i ? 2'd1 : 2'd0;
            w_state_nxt = S_FETCH;
          end
          C_FENCE: begin
            w_pc_we     = 1'b1;
            w_state_nxt = S_FETCH;
          end
          C_LOAD, C_STORE: w_state_nxt = S_MEM;
          default:         w_state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        w_mem_req  = 1'b1;
        w_addr_sel = 1'b1;
        w_mem_we   = (r_cls == C_STORE);
        if (mem_ready_i) begin
          if (r_cls == C_STORE) begin
            w_pc_we     = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_WB;
          end
        end else if (w_timeout) begin
          w_fault_nxt = FLT_TIMEOUT;
          w_state_nxt = S_HALT;
        end
      end
      S_WB: begin
        w_rd_we = 1'b1;
        w_pc_we = 1'b1;
        case (r_cls)
          C_LOAD:  w_wb_sel = 2'd1;
          C_JAL:   begin w_wb_sel = 2'd2; w_pc_sel = 2'd1; end
          C_JALR:  begin w_wb_sel = 2'd2; w_pc_sel = 2'd2; end
          default: w_wb_sel = 2'd0;
        endcase
        w_state_nxt = S_FETCH;
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Decoded controls are forced low while reset is asserted (state already reads FETCH).
  assign mem_req_o      = rst_ni & w_mem_req;
  assign mem_we_o       = rst_ni & w_mem_we;
  assign mem_addr_sel_o = rst_ni & w_addr_sel;
  assign ir_we_o        = rst_ni & w_ir_we;
  assign alu_a_sel_o    = rst_ni & w_a_sel;
  assign alu_b_sel_o    = rst_ni & w_b_sel;
  assign pc_we_o        = rst_ni & w_pc_we;
  assign rd_we_o        = rst_ni & w_rd_we;
  assign pc_sel_o       = rst_ni ? w_pc_sel : 2'd0;
  assign wb_sel_o       = rst_ni ? w_wb_sel : 2'd0;
  assign ImmSel_o       = r_imm_sel;
  assign halt_o         = r_halt;
  assign fault_o        = r_fault;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: cycle-by-cycle check of multicycle_ctrl against a
// phase-level instruction model (MEM_TIMEOUT = 4).
module tb_multicycle_ctrl;

  localparam int unsigned T = 4;
  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                         JALR = 7'b1100111, BR = 7'b1100011, LD = 7'b0000011,
                         ST = 7'b0100011, OPI = 7'b0010011, OPR = 7'b0110011,
                         FENCE = 7'b0001111, SYS = 7'b1110011;

  localparam logic [2:0] PH_F = 3'd0, PH_D = 3'd1, PH_E = 3'd2, PH_M = 3'd3, PH_W = 3'd4, PH_H = 3'd5;

  typedef struct packed {
    logic       req;
    logic       we;
    logic       addr_sel;
    logic       ir_we;
    logic [2:0] imm;
    logic       a_sel;
    logic       b_sel;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rd_we;
    logic [1:0] wb_sel;
    logic       halt;
    logic [1:0] fault;
  } outv_t;

  typedef struct packed {
    logic       ready;
    logic       br;
    logic [2:0] ph;
    outv_t      exp;
  } step_t;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [6:0] opcode_i = 7'd0;
  logic       br_taken_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       mem_req_o, mem_we_o, mem_addr_sel_o, ir_we_o;
  logic [2:0] ImmSel_o;
  logic       alu_a_sel_o, alu_b_sel_o, pc_we_o, rd_we_o, halt_o;
  logic [1:0] pc_sel_o, wb_sel_o, fault_o;

  int         n_checks = 0;
  int         n_err = 0;
  step_t      q[$];
  logic       m_halt = 1'b0;
  logic [1:0] m_fault = 2'd0;
  logic [2:0] m_imm = IMM_I;
  outv_t      w_obs;

  multicycle_ctrl #(.MEM_TIMEOUT(T), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i), .br_taken_i(br_taken_i),
    .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_sel_o(mem_addr_sel_o), .ir_we_o(ir_we_o), .ImmSel_o(ImmSel_o),
    .alu_a_sel_o(alu_a_sel_o), .alu_b_sel_o(alu_b_sel_o), .pc_we_o(pc_we_o),
    .pc_sel_o(pc_sel_o), .rd_we_o(rd_we_o), .wb_sel_o(wb_sel_o),
    .halt_o(halt_o), .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  assign w_obs = {mem_req_o, mem_we_o, mem_addr_sel_o, ir_we_o, ImmSel_o, alu_a_sel_o,
                  alu_b_sel_o, pc_we_o, pc_sel_o, rd_we_o, wb_sel_o, halt_o, fault_o};

  function automatic void push(input logic rdy, input logic br, input logic [2:0] ph, input outv_t e);
    step_t s;
    s.ready = rdy; s.br = br; s.ph = ph; s.exp = e;
    q.push_back(s);
  endfunction

  function automatic outv_t base();
    outv_t e;
    e = '0;
    e.imm = m_imm; e.halt = m_halt; e.fault = m_fault;
    return e;
  endfunction

  // Enter halt: three parked cycles with ready pulsing.
  function automatic void enter_halt(input logic [1:0] f, input logic br);
    m_halt = 1'b1; m_fault = f;
    for (int k = 0; k < 3; k++) push(~k[0], br, PH_H, base());
  endfunction

  // Expected per-cycle trace of one instruction. fw/mw = ready-low cycles
  // before ready in FETCH/MEM; more than T of them times out.
  function automatic void model_instr(input logic [6:0] op, input logic br, input int fw, input int mw);
    outv_t e;
    logic [2:0] imm;
    logic [1:0] flt;
    if (m_halt) begin
      for (int k = 0; k < 3; k++) push(k[0], br, PH_H, base());
      return;
    end
    for (int k = 0; k <= int'(T); k++) begin
      e = base(); e.req = 1'b1;
      if (k == fw) begin
        e.ir_we = 1'b1; push(1'b1, br, PH_F, e); break;
      end
      push(1'b0, br, PH_F, e);
      if (k == int'(T)) begin enter_halt(2'd2, br); return; end
    end
    push(1'($urandom), br, PH_D, base());
    flt = 2'd0;
    case (op)
      LUI, AUIPC:      imm = IMM_U;
      JAL:             imm = IMM_J;
      JALR, LD, OPI:   imm = IMM_I;
      ST:              imm = IMM_S;
      BR:              imm = IMM_B;
      OPR, FENCE:      imm = IMM_I;
      SYS:             begin imm = IMM_I; flt = 2'd3; end
      default:         begin imm = IMM_I; flt = 2'd1; end
    endcase
    m_imm = imm;
    if (flt != 2'd0) begin enter_halt(flt, br); return; end
    e = base();
    e.a_sel = (op == AUIPC) || (op == JAL) || (op == BR);
    e.b_sel = (op != OPR);
    if (op == BR || op == FENCE) begin
      e.pc_we = 1'b1;
      e.pc_sel = (op == BR && br) ? 2'd1 : 2'd0;
      push(1'($urandom), br, PH_E, e);
      return;
    end
    push(1'($urandom), br, PH_E, e);
    if (op == LD || op == ST) begin
      for (int k = 0; k <= int'(T); k++) begin
        e = base(); e.req = 1'b1; e.addr_sel = 1'b1; e.we = (op == ST);
        if (k == mw) begin
          e.pc_we = (op == ST);
          push(1'b1, br, PH_M, e);
          break;
        end
        push(1'b0, br, PH_M, e);
        if (k == int'(T)) begin enter_halt(2'd2, br); return; end
      end
      if (op == ST) return;
    end
    e = base(); e.rd_we = 1'b1; e.pc_we = 1'b1;
    e.wb_sel = (op == LD) ? 2'd1 : ((op == JAL || op == JALR) ? 2'd2 : 2'd0);
    e.pc_sel = (op == JAL) ? 2'd1 : ((op == JALR) ? 2'd2 : 2'd0);
    push(1'($urandom), br, PH_W, e);
  endfunction

  task automatic check_vec(input string tag, input outv_t e);
    n_checks++;
    assert (w_obs === e) else begin
      n_err++;
      $error("FAIL %s op=%b obs=%h exp=%h", tag, opcode_i, w_obs, e);
    end
  endtask

  // Entered and left at posedge+1; outputs sampled on the falling edge.
  task automatic run_steps(input int n);
    step_t s;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      s = q.pop_front();
      mem_ready_i = s.ready;
      br_taken_i  = s.br;
      @(negedge clk_i);
      check_vec($sformatf("ph%0d", s.ph), s.exp);
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    mem_ready_i = 1'b1;
    #1;
    check_vec("rst_async", '0);
    @(posedge clk_i);
    #1;
    check_vec("rst_hold", '0);
    rst_ni = 1'b1;
    m_halt = 1'b0; m_fault = 2'd0; m_imm = IMM_I;
    q.delete();
  endtask

  task automatic run_instr(input logic [6:0] op, input logic br, input int fw, input int mw);
    opcode_i = op;
    model_instr(op, br, fw, mw);
    run_steps(1000);
    if (m_halt) do_reset();
  endtask

  logic [6:0] op_tab [10];
  logic [6:0] r_op;

  initial begin
    op_tab = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OPR, FENCE};
    @(posedge clk_i);
    #1;
    do_reset();

    run_instr(OPI, 1'b0, 0, 0);
    run_instr(LD, 1'b0, 0, 2);
    run_instr(ST, 1'b0, 0, 2);
    run_instr(BR, 1'b1, 0, 0);
    run_instr(BR, 1'b0, 0, 0);
    run_instr(JAL, 1'b0, 0, 0);
    run_instr(JALR, 1'b0, 0, 0);
    run_instr(LUI, 1'b0, 1, 0);
    run_instr(AUIPC, 1'b0, 0, 0);
    run_instr(OPR, 1'b0, 0, 0);
    run_instr(FENCE, 1'b0, 0, 0);

    run_instr(OPI, 1'b0, 99, 0);
    run_instr(OPI, 1'b0, int'(T), 0);
    run_instr(LD, 1'b0, 0, int'(T));
    run_instr(ST, 1'b0, 0, 99);

    run_instr(7'b1111111, 1'b0, 0, 0);
    run_instr(SYS, 1'b0, 0, 0);

    opcode_i = LD;
    model_instr(LD, 1'b0, 0, 99);
    run_steps(4);
    do_reset();
    run_instr(OPI, 1'b0, 0, 0);

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 15))
        0:       r_op = SYS;
        1:       r_op = 7'($urandom);
        default: r_op = op_tab[$urandom_range(0, 9)];
      endcase
      run_instr(r_op, 1'($urandom),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 2)),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
